// File: rtl/inst_queue.sv
// Dual-lane instruction queue: circular buffer with up to two pushes and two
// pops per cycle, a global stall and a mispredict flush.
module inst_queue #(
  parameter int DATA_W    = 88,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic [1:0]                 push_valid,
  input  logic [DATA_W-1:0]          push_data0,
  input  logic [DATA_W-1:0]          push_data1,
  output logic [1:0]                 push_ready,
  output logic [DATA_W-1:0]          pop_data0,
  output logic [DATA_W-1:0]          pop_data1,
  output logic [1:0]                 pop_valid,
  input  logic [1:0]                 pop_en,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       almost_full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshake: a lane transfers when its valid/en and ready/valid are both high
  // on a rising clock with rdy_in=1; lane 1 only ever transfers together with lane 0.

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [CW-1:0] free_slots;
  logic [PW-1:0] rd_ptr_p1;
  logic [PW-1:0] wr_ptr_p1;
  logic          do_pop0, do_pop1, do_push0, do_push1;
  logic [1:0]    pop_cnt, push_cnt;
  logic          update_en;

  assign free_slots = CW'(DEPTH) - count_q;
  assign rd_ptr_p1  = rd_ptr_q + PW'(1);
  assign wr_ptr_p1  = wr_ptr_q + PW'(1);

  assign pop_valid[0]  = (count_q > CW'(0));
  assign pop_valid[1]  = (count_q > CW'(1));
  assign push_ready[0] = (free_slots > CW'(0));
  assign push_ready[1] = (free_slots > CW'(1));

  assign pop_data0 = pop_valid[0] ? mem_q[rd_ptr_q]  : '0;
  assign pop_data1 = pop_valid[1] ? mem_q[rd_ptr_p1] : '0;

  assign count       = count_q;
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == CW'(0));
  assign almost_full = ({{(32-CW){1'b0}}, free_slots} <= 32'(AF_MARGIN));

  assign do_pop0  = pop_en[0] && pop_valid[0];
  assign do_pop1  = do_pop0 && pop_en[1] && pop_valid[1];
  assign do_push0 = push_valid[0] && push_ready[0];
  assign do_push1 = do_push0 && push_valid[1] && push_ready[1];

  assign pop_cnt  = do_pop1  ? 2'd2 : (do_pop0  ? 2'd1 : 2'd0);
  assign push_cnt = do_push1 ? 2'd2 : (do_push0 ? 2'd1 : 2'd0);

  // Storage writes only in a normal (unstalled, unflushed, out-of-reset) cycle.
  assign update_en = rst_n_in && rdy_in && !flush_in;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (rdy_in) begin
      if (flush_in) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
      end else begin
        rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
        wr_ptr_d = wr_ptr_q + PW'(push_cnt);
        count_d  = count_q + CW'(push_cnt) - CW'(pop_cnt);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Validity is carried by count alone, so the array is never cleared.
  always_ff @(posedge clk_in) begin
    if (update_en && do_push0) mem_q[wr_ptr_q]  <= push_data0;
    if (update_en && do_push1) mem_q[wr_ptr_p1] <= push_data1;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: a queue model tracks expected contents
// and every cycle's outputs are compared against it, plus directed scenarios.
module tb_inst_queue;

  localparam int DATA_W    = 88;
  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 2;
  localparam int CW        = $clog2(DEPTH+1);

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              rdy_in;
  logic              flush_in;
  logic [1:0]        push_valid;
  logic [DATA_W-1:0] push_data0;
  logic [DATA_W-1:0] push_data1;
  logic [1:0]        push_ready;
  logic [DATA_W-1:0] pop_data0;
  logic [DATA_W-1:0] pop_data1;
  logic [1:0]        pop_valid;
  logic [1:0]        pop_en;
  logic [CW-1:0]     count;
  logic              full;
  logic              almost_full;
  logic              empty;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_d0;
  logic [DATA_W-1:0] idx0_data;

  inst_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .push_valid(push_valid), .push_data0(push_data0), .push_data1(push_data1),
    .push_ready(push_ready), .pop_data0(pop_data0), .pop_data1(pop_data1),
    .pop_valid(pop_valid), .pop_en(pop_en), .count(count), .full(full),
    .almost_full(almost_full), .empty(empty)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard comparison of every output against the model contents.
  task automatic check_outputs();
    int sz;
    int fr;
    logic [DATA_W-1:0] e0, e1;
    sz = exp_q.size();
    fr = DEPTH - sz;
    e0 = (sz > 0) ? exp_q[0] : '0;
    e1 = (sz > 1) ? exp_q[1] : '0;
    check("count", DATA_W'(count), DATA_W'(sz));
    check("empty", DATA_W'(empty), DATA_W'(sz == 0));
    check("full", DATA_W'(full), DATA_W'(sz == DEPTH));
    check("almost_full", DATA_W'(almost_full), DATA_W'(fr <= AF_MARGIN));
    check("push_ready", DATA_W'(push_ready), DATA_W'({fr > 1, fr > 0}));
    check("pop_valid", DATA_W'(pop_valid), DATA_W'({sz > 1, sz > 0}));
    check("pop_data0", pop_data0, e0);
    check("pop_data1", pop_data1, e1);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DATA_W-1:0];
  endfunction

  // Driver: applies one cycle of stimulus, advances the model, then checks.
  task automatic cycle(input logic [1:0] pv, input logic [1:0] pe,
                       input logic rdy, input logic fl, input logic rst_n);
    int sz;
    int fr;
    int npop;
    int npush;
    logic [DATA_W-1:0] d0, d1;
    d0 = rand_data();
    d1 = rand_data();
    last_d0    = d0;
    push_valid = pv;
    pop_en     = pe;
    rdy_in     = rdy;
    flush_in   = fl;
    rst_n_in   = rst_n;
    push_data0 = d0;
    push_data1 = d1;
    sz = exp_q.size();
    fr = DEPTH - sz;
    npop  = (pe[0] && sz > 0) ? ((pe[1] && sz > 1) ? 2 : 1) : 0;
    npush = (pv[0] && fr > 0) ? ((pv[1] && fr > 1) ? 2 : 1) : 0;
    @(posedge clk_in);
    #1;
    if (!rst_n || (rdy && fl)) begin
      exp_q.delete();
    end else if (rdy) begin
      for (int i = 0; i < npop; i++) void'(exp_q.pop_front());
      if (npush > 0) exp_q.push_back(d0);
      if (npush > 1) exp_q.push_back(d1);
    end
    check_outputs();
  endtask

  initial begin
    push_valid = '0; pop_en = '0; rdy_in = 1'b0; flush_in = 1'b0;
    rst_n_in = 1'b0; push_data0 = '0; push_data1 = '0;

    // Reset, with rdy_in low to show reset dominates the stall
    cycle(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    check("rst_push_ready", DATA_W'(push_ready), DATA_W'(2'b11));
    check("rst_empty", DATA_W'(empty), DATA_W'(1));

    // Fill with dual pushes
    for (int i = 0; i < 8; i++) cycle(2'b11, 2'b00, 1'b1, 1'b0, 1'b1);
    check("fill_count", DATA_W'(count), DATA_W'(16));
    check("fill_full", DATA_W'(full), DATA_W'(1));
    check("fill_push_ready", DATA_W'(push_ready), DATA_W'(2'b00));
    cycle(2'b11, 2'b00, 1'b1, 1'b0, 1'b1);

    // Move rd_ptr to 14, then refill to 15 entries across the wrap
    for (int i = 0; i < 7; i++) cycle(2'b00, 2'b11, 1'b1, 1'b0, 1'b1);
    cycle(2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
    idx0_data = last_d0;
    for (int i = 0; i < 6; i++) cycle(2'b11, 2'b00, 1'b1, 1'b0, 1'b1);
    check("wrap_pre_count", DATA_W'(count), DATA_W'(15));
    check("wrap_push_ready", DATA_W'(push_ready), DATA_W'(2'b01));
    cycle(2'b11, 2'b11, 1'b1, 1'b0, 1'b1);
    check("wrap_count", DATA_W'(count), DATA_W'(14));
    check("wrap_pop_data0", pop_data0, idx0_data);

    // Drain
    for (int i = 0; i < 7; i++) cycle(2'b00, 2'b11, 1'b1, 1'b0, 1'b1);

    // Push and pop together while empty
    cycle(2'b11, 2'b11, 1'b1, 1'b0, 1'b1);
    check("empty_sim_count", DATA_W'(count), DATA_W'(2));
    check("empty_sim_data0", pop_data0, last_d0);

    // Illegal lane patterns
    cycle(2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
    cycle(2'b00, 2'b10, 1'b1, 1'b0, 1'b1);
    check("illegal_pop_count", DATA_W'(count), DATA_W'(3));
    cycle(2'b10, 2'b00, 1'b1, 1'b0, 1'b1);
    check("illegal_push_count", DATA_W'(count), DATA_W'(3));

    // Stall then flush
    cycle(2'b11, 2'b00, 1'b1, 1'b0, 1'b1);
    check("pre_flush_count", DATA_W'(count), DATA_W'(5));
    cycle(2'b11, 2'b11, 1'b0, 1'b1, 1'b1);
    check("stall_flush_count", DATA_W'(count), DATA_W'(5));
    cycle(2'b01, 2'b00, 1'b1, 1'b1, 1'b1);
    check("flush_count", DATA_W'(count), DATA_W'(0));
    check("flush_empty", DATA_W'(empty), DATA_W'(1));

    // Reset mid-stream during a stall
    for (int i = 0; i < 4; i++) cycle(2'b11, 2'b00, 1'b1, 1'b0, 1'b1);
    cycle(2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
    check("pre_rst_count", DATA_W'(count), DATA_W'(9));
    cycle(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    check("mid_rst_count", DATA_W'(count), DATA_W'(0));
    check("mid_rst_pop_valid", DATA_W'(pop_valid), DATA_W'(2'b00));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 199) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 88, meaning width of one queued entry (bits).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning entry capacity; it SHALL be a power of two, 4 or greater.
REQ-003 The block SHALL have parameter AF_MARGIN, default 2, meaning almost_full asserts when free slots are AF_MARGIN or fewer.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have these ports:
clk_in  in  1  clock
rst_n_in  in  1  synchronous active-low reset
rdy_in  in  1  global ready; 0 = stall
flush_in  in  1  discard all contents (mispredict)
push_valid  in  2  per-lane push request; lane 1 is valid only with lane 0
push_data0  in  DATA_W  lane 0 entry (older)
push_data1  in  DATA_W  lane 1 entry (younger)
push_ready  out  2  per-lane push acceptance
pop_data0  out  DATA_W  oldest entry
pop_data1  out  DATA_W  second-oldest entry
pop_valid  out  2  per-lane entry present
pop_en  in  2  per-lane consume request
count  out  $clog2(DEPTH+1)  occupied entries
full  out  1  count == DEPTH
almost_full  out  1  DEPTH - count <= AF_MARGIN
empty  out  1  count == 0

Function
REQ-006 Storage SHALL be a circular buffer with read pointer rd_ptr and write pointer wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH through natural overflow.
REQ-007 Full capacity SHALL be DEPTH entries, tracked by count, with no sacrificed slot.
REQ-008 pop_valid[k] SHALL be 1 if and only if count > k; pop_dataK SHALL be the entry at (rd_ptr+k) mod DEPTH when valid, and zero otherwise.
REQ-009 push_ready[k] SHALL be 1 if and only if (DEPTH - count) > k, computed from registered count only, so a same-cycle pop does not free space.
REQ-010 Pops per cycle SHALL be: 0 if !(pop_en[0]&&pop_valid[0]); 1 if lane 0 pops and !(pop_en[1]&&pop_valid[1]); otherwise 2.
REQ-011 pop_en[1] without pop_en[0] SHALL be ignored.
REQ-012 Pushes per cycle SHALL be: 0 if !(push_valid[0]&&push_ready[0]); 1 if lane 0 pushes and !(push_valid[1]&&push_ready[1]); otherwise 2.
REQ-013 push_valid[1] without push_valid[0] SHALL be ignored.
REQ-014 Lane 0 SHALL be written at wr_ptr and lane 1 at wr_ptr+1, preserving order.
REQ-015 On a rising clock with rdy_in=1 and no flush, the block SHALL update in one cycle: rd_ptr += pops, wr_ptr += pushes, count += pushes - pops.
REQ-016 Simultaneous push and pop SHALL both take effect, including when empty (a push is not visible until the next cycle; no bypass) and when full (pushes are refused per REQ-009).
REQ-017 A write slot SHALL never alias an unpopped entry.
REQ-018 rdy_in=0 SHALL freeze pointers, count and storage; outputs SHALL remain driven from the frozen state, and push/pop in that cycle have no effect.
REQ-019 flush_in=1 with rdy_in=1 SHALL, on the next cycle, zero rd_ptr, wr_ptr and count, discarding any same-cycle push and pop.
REQ-020 flush_in SHALL be ignored while rdy_in=0.
REQ-021 Priority SHALL be: reset > stall (rdy_in=0) > flush > normal operation.
REQ-022 full, almost_full and empty SHALL be combinational from registered count.
REQ-023 Storage contents SHALL need no clearing; validity is defined solely by count.

Reset
REQ-024 When rst_n_in=0 at a rising clock, regardless of rdy_in, rd_ptr, wr_ptr and count SHALL become 0.
REQ-025 Reset values SHALL be: pop_valid=00, pop_data0/1=0, empty=1, full=0, push_ready=11, and almost_full=(DEPTH<=AF_MARGIN).
REQ-026 Reset asserted mid-operation SHALL discard all entries and in-flight push/pop.

Verification
REQ-027 Dual push with DEPTH=16 from reset: push A,B each cycle for 8 cycles -> count=16, full=1, push_ready=00, almost_full asserted from count=14.
REQ-028 Wrap-around: with count=15 and rd_ptr=14, dual pop + dual push -> push_ready=01, exactly 1 accepted, count=14, and the next pop_data0 is the entry previously at index 0.
REQ-029 Empty simultaneity: with count=0, push_valid=11 and pop_en=11 -> pops ignored, count=2 next cycle, pop_data0=lane0 data.
REQ-030 Stall then flush: with count=5, rdy_in=0 and flush_in=1 -> count stays 5; then rdy_in=1 and flush_in=1 with push_valid=01 -> count=0 and empty=1.
REQ-031 Illegal lanes: pop_en=10 with count=3 -> count stays 3; push_valid=10 -> no write.
REQ-032 Reset mid-stream: with count=9, rst_n_in=0 for 1 cycle while rdy_in=0 -> count=0 and pop_valid=00 on the next cycle.
